// File: rtl/ulpi_rx_stream_if.sv
// AXI4-Stream byte channel carrying received USB packets to the packet decoder.
// master drives tvalid/tlast/tdata, slave drives tready.
interface ulpi_rx_stream_if;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic [7:0] tdata;

   modport master (output tvalid, output tlast, output tdata, input tready);
   modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/ulpi_rx_stream.sv
// ULPI receive framer: classifies PHY bus cycles, strips RX CMDs and emits one
// AXI4-Stream packet per USB packet through a small first-word-fall-through FIFO.
module ulpi_rx_stream #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  ulpi_dir_i,
   input  logic                  ulpi_nxt_i,
   input  logic [7:0]            ulpi_data_i,
   ulpi_rx_stream_if.master      m_axis,
   output logic [1:0]            linestate_o,
   output logic [1:0]            vbus_o,
   output logic                  rx_active_o,
   output logic                  rx_error_o,
   output logic                  overflow_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {StIdle, StTurn, StRecv, StDrop} state_e;

   state_e state_q, state_d;

   logic          dir_q;
   logic [7:0]    hold_q;
   logic          hold_vld_q;
   logic [1:0]    linestate_q;
   logic [1:0]    vbus_q;
   logic          rx_error_q;
   logic          overflow_q;
   logic [PW-1:0] wptr_q, rptr_q;
   logic [8:0]    mem_q [FIFO_DEPTH];

   // Cycle classification
   logic turn, rx_cmd, data_cyc, rx_active_ev, rx_err_ev, eop;

   // Control decoded from the FSM
   logic push_req, push_last, hold_load, hold_clr, ovf_set, err_clr;

   // FIFO status
   logic empty, full, rd_en, wr_ok, wr_en;

   assign turn         = ulpi_dir_i & ~dir_q;
   assign rx_cmd       = ulpi_dir_i & ~ulpi_nxt_i & ~turn;
   assign data_cyc     = ulpi_dir_i & ulpi_nxt_i & ~turn;
   assign rx_active_ev = rx_cmd & ulpi_data_i[4];
   assign rx_err_ev    = rx_cmd & (ulpi_data_i[5:4] == 2'b11);
   assign eop          = ~ulpi_dir_i | (rx_cmd & ~ulpi_data_i[4]);

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rd_en = ~empty & m_axis.tready;
   // A slot freed by a same-cycle read can take the incoming byte.
   assign wr_ok = ~full | rd_en;
   assign wr_en = push_req & wr_ok;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (turn) begin
               state_d = ulpi_nxt_i ? StRecv : StTurn;
            end
         end
         StTurn: begin
            if (!ulpi_dir_i) begin
               state_d = StIdle;
            end else if (data_cyc || rx_active_ev) begin
               state_d = StRecv;
            end
         end
         StRecv: begin
            if (eop) begin
               state_d = StIdle;
            end else if (data_cyc && hold_vld_q && !wr_ok) begin
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (eop) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output / control logic
   always_comb begin
      push_req    = 1'b0;
      push_last   = 1'b0;
      hold_load   = 1'b0;
      hold_clr    = 1'b0;
      ovf_set     = 1'b0;
      rx_active_o = (state_q == StRecv) || (state_q == StDrop);
      err_clr     = (state_d == StRecv) && (state_q != StRecv);
      unique case (state_q)
         StTurn: begin
            hold_load = data_cyc;
         end
         StRecv: begin
            if (eop) begin
               push_req  = hold_vld_q;
               push_last = 1'b1;
               hold_clr  = 1'b1;
            end else if (data_cyc) begin
               push_req  = hold_vld_q;
               hold_load = 1'b1;
            end
         end
         default: ;
      endcase
      // Overflow: drop the pending byte and discard the rest of the packet.
      if (push_req && !wr_ok) begin
         ovf_set   = 1'b1;
         hold_load = 1'b0;
         hold_clr  = 1'b1;
      end
   end

   // Datapath and status registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dir_q       <= 1'b0;
         hold_q      <= 8'h00;
         hold_vld_q  <= 1'b0;
         linestate_q <= 2'b00;
         vbus_q      <= 2'b00;
         rx_error_q  <= 1'b0;
         overflow_q  <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
      end else begin
         dir_q <= ulpi_dir_i;
         if (hold_load) begin
            hold_q     <= ulpi_data_i;
            hold_vld_q <= 1'b1;
         end else if (hold_clr) begin
            hold_vld_q <= 1'b0;
         end
         if (rx_cmd) begin
            linestate_q <= ulpi_data_i[1:0];
            vbus_q      <= ulpi_data_i[3:2];
         end
         if (rx_err_ev) begin
            rx_error_q <= 1'b1;
         end else if (err_clr) begin
            rx_error_q <= 1'b0;
         end
         if (ovf_set) begin
            overflow_q <= 1'b1;
         end
         if (wr_en) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (rd_en) begin
            rptr_q <= rptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wptr_q[AW-1:0]] <= {push_last, hold_q};
      end
   end

   // Gate the read port so an empty FIFO shows all-zero outputs.
   assign m_axis.tvalid = ~empty;
   assign m_axis.tdata  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]][7:0];
   assign m_axis.tlast  = empty ? 1'b0 : mem_q[rptr_q[AW-1:0]][8];

   assign linestate_o = linestate_q;
   assign vbus_o      = vbus_q;
   assign rx_error_o  = rx_error_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ulpi_rx_stream.sv
// Bench for ulpi_rx_stream: cycle vector table, hand-written overflow and reset
// sequences, then randomized packets checked against a packet-level stream model.
module tb_ulpi_rx_stream;

   localparam int unsigned Depth = 4;

   typedef logic [7:0] byte_q_t [$];

   typedef struct {
      logic       dir;
      logic       nxt;
      logic [7:0] data;
      logic [1:0] ls;
      logic [1:0] vb;
      logic       act;
      logic       err;
      logic       tv;
      logic       tl;
      logic [7:0] td;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       ulpi_dir, ulpi_nxt;
   logic [7:0] ulpi_data;
   logic [1:0] linestate, vbus;
   logic       rx_active, rx_error, overflow;

   ulpi_rx_stream_if axis ();

   ulpi_rx_stream #(.FIFO_DEPTH(Depth)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ulpi_dir_i  (ulpi_dir),
      .ulpi_nxt_i  (ulpi_nxt),
      .ulpi_data_i (ulpi_data),
      .m_axis      (axis.master),
      .linestate_o (linestate),
      .vbus_o      (vbus),
      .rx_active_o (rx_active),
      .rx_error_o  (rx_error),
      .overflow_o  (overflow)
   );

   always #8 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] got_q [$];
   logic [8:0] exp_q [$];
   logic [1:0] m_ls, m_vb;

   always @(negedge clock) begin
      if (reset_n && axis.tvalid && axis.tready) got_q.push_back({axis.tlast, axis.tdata});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bus(input logic d, input logic n, input logic [7:0] x);
      ulpi_dir  = d;
      ulpi_nxt  = n;
      ulpi_data = x;
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t v(int d, int n, int x, int ls, int vb, int act, int err,
                              int tv, int tl, int td);
      vec_t r;
      r.dir = d[0]; r.nxt = n[0]; r.data = x[7:0]; r.ls = ls[1:0]; r.vb = vb[1:0];
      r.act = act[0]; r.err = err[0]; r.tv = tv[0]; r.tl = tl[0]; r.td = td[7:0];
      return r;
   endfunction

   task automatic expect_pkt(input byte_q_t b);
      foreach (b[i]) exp_q.push_back({(i == b.size() - 1), b[i]});
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 200 && axis.tvalid; i++) begin
         @(posedge clock);
         #1;
      end
      chk("drain_timeout", {31'd0, axis.tvalid}, 32'd0);
   endtask

   // Sends one packet; the expected stream is simply the payload with tlast on its final byte.
   task automatic send_pkt(input byte_q_t b, input bit turn_nxt, input bit eop_cmd,
                           input int cmd_pct);
      logic [7:0] c;
      if (turn_nxt) begin
         bus(1'b1, 1'b1, 8'($urandom));
      end else begin
         bus(1'b1, 1'b0, 8'($urandom));
         c = {2'($urandom), 2'b01, 4'($urandom)};
         bus(1'b1, 1'b0, c);
         m_ls = c[1:0]; m_vb = c[3:2];
      end
      foreach (b[i]) begin
         if ($urandom_range(99) < cmd_pct) begin
            c = {2'($urandom), 2'b01, 4'($urandom)};
            bus(1'b1, 1'b0, c);
            m_ls = c[1:0]; m_vb = c[3:2];
         end
         bus(1'b1, 1'b1, b[i]);
      end
      if (eop_cmd) begin
         c = {2'($urandom), 1'($urandom), 1'b0, 4'($urandom)};
         bus(1'b1, 1'b0, c);
         m_ls = c[1:0]; m_vb = c[3:2];
      end
      bus(1'b0, 1'b0, 8'h00);
      expect_pkt(b);
      chk("pkt_rx_active", {31'd0, rx_active}, 32'd0);
      chk("pkt_rx_error", {31'd0, rx_error}, 32'd0);
      chk("pkt_linestate", {30'd0, linestate}, {30'd0, m_ls});
      chk("pkt_vbus", {30'd0, vbus}, {30'd0, m_vb});
   endtask

   vec_t tbl [26];

   initial begin
      byte_q_t pkt;

      // Status and stream outputs expected just after each cycle's clock edge.
      //         dir nxt data  ls vb act err tv tl td
      tbl[0]  = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 'h00);
      tbl[1]  = v(1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 'h00);
      tbl[2]  = v(1, 0, 'h01, 1, 0, 0, 0, 0, 0, 'h00);
      tbl[3]  = v(1, 0, 'h0E, 2, 3, 0, 0, 0, 0, 'h00);
      tbl[4]  = v(1, 0, 'h1C, 0, 3, 1, 0, 0, 0, 'h00);
      tbl[5]  = v(1, 1, 'hA5, 0, 3, 1, 0, 0, 0, 'h00);
      tbl[6]  = v(1, 1, 'h12, 0, 3, 1, 0, 1, 0, 'hA5);
      tbl[7]  = v(1, 1, 'h34, 0, 3, 1, 0, 1, 0, 'h12);
      tbl[8]  = v(1, 0, 'h00, 0, 0, 0, 0, 1, 1, 'h34);
      tbl[9]  = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 'h00);
      tbl[10] = v(1, 1, 'h00, 0, 0, 1, 0, 0, 0, 'h00);
      tbl[11] = v(1, 1, 'hA5, 0, 0, 1, 0, 0, 0, 'h00);
      tbl[12] = v(1, 1, 'h12, 0, 0, 1, 0, 1, 0, 'hA5);
      tbl[13] = v(1, 1, 'h34, 0, 0, 1, 0, 1, 0, 'h12);
      tbl[14] = v(0, 0, 'h00, 0, 0, 0, 0, 1, 1, 'h34);
      tbl[15] = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 'h00);
      tbl[16] = v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 'h00);
      tbl[17] = v(1, 0, 'h11, 1, 0, 1, 0, 0, 0, 'h00);
      tbl[18] = v(1, 1, 'h5A, 1, 0, 1, 0, 0, 0, 'h00);
      tbl[19] = v(1, 0, 'h31, 1, 0, 1, 1, 0, 0, 'h00);
      tbl[20] = v(1, 1, 'hC3, 1, 0, 1, 1, 1, 0, 'h5A);
      tbl[21] = v(1, 0, 'h01, 1, 0, 0, 1, 1, 1, 'hC3);
      tbl[22] = v(0, 0, 'h00, 1, 0, 0, 1, 0, 0, 'h00);
      tbl[23] = v(1, 0, 'h00, 1, 0, 0, 1, 0, 0, 'h00);
      tbl[24] = v(1, 0, 'h10, 0, 0, 1, 0, 0, 0, 'h00);
      tbl[25] = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 'h00);

      reset_n = 1'b0;
      ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data = 8'h00;
      axis.tready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_tvalid", {31'd0, axis.tvalid}, 32'd0);
      chk("reset_status", {25'd0, linestate, vbus, rx_active, rx_error, overflow}, 32'd0);
      reset_n = 1'b1;

      // Vector table
      for (int i = 0; i < 26; i++) begin
         bus(tbl[i].dir, tbl[i].nxt, tbl[i].data);
         chk($sformatf("vec%0d_linestate", i), {30'd0, linestate}, {30'd0, tbl[i].ls});
         chk($sformatf("vec%0d_vbus", i), {30'd0, vbus}, {30'd0, tbl[i].vb});
         chk($sformatf("vec%0d_rx_active", i), {31'd0, rx_active}, {31'd0, tbl[i].act});
         chk($sformatf("vec%0d_rx_error", i), {31'd0, rx_error}, {31'd0, tbl[i].err});
         chk($sformatf("vec%0d_tvalid", i), {31'd0, axis.tvalid}, {31'd0, tbl[i].tv});
         if (tbl[i].tv) begin
            chk($sformatf("vec%0d_tdata", i), {24'd0, axis.tdata}, {24'd0, tbl[i].td});
            chk($sformatf("vec%0d_tlast", i), {31'd0, axis.tlast}, {31'd0, tbl[i].tl});
         end
      end
      pkt = '{8'hA5, 8'h12, 8'h34}; expect_pkt(pkt); expect_pkt(pkt);
      pkt = '{8'h5A, 8'hC3}; expect_pkt(pkt);

      // Overflow: 7-byte packet into a stalled 4-entry FIFO.
      axis.tready = 1'b0;
      bus(1'b1, 1'b1, 8'h00);
      for (int i = 1; i <= 7; i++) begin
         bus(1'b1, 1'b1, 8'(i));
         if (i == 5) begin
            chk("ovf_before_full", {31'd0, overflow}, 32'd0);
            chk("ovf_head_tdata", {24'd0, axis.tdata}, 32'h01);
         end
         if (i >= 6) begin
            chk("ovf_flag", {31'd0, overflow}, 32'd1);
            chk("ovf_drop_active", {31'd0, rx_active}, 32'd1);
         end
      end
      bus(1'b0, 1'b0, 8'h00);
      chk("ovf_eop_active", {31'd0, rx_active}, 32'd0);
      chk("ovf_tvalid_held", {31'd0, axis.tvalid}, 32'd1);
      // Partial packet is not retro-tagged with tlast.
      for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, 8'(i)});
      axis.tready = 1'b1;
      drain();
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      pkt = '{8'h21, 8'h43, 8'h65};
      m_ls = linestate; m_vb = vbus;
      send_pkt(pkt, 1'b0, 1'b1, 0);
      drain();

      // Asynchronous reset in the middle of a packet, with stale data still queued.
      axis.tready = 1'b0;
      bus(1'b1, 1'b1, 8'h00);
      bus(1'b1, 1'b1, 8'hE1);
      bus(1'b1, 1'b1, 8'hE2);
      bus(1'b0, 1'b0, 8'h00);
      bus(1'b1, 1'b0, 8'h00);
      bus(1'b1, 1'b0, 8'h15);
      bus(1'b1, 1'b1, 8'hB1);
      ulpi_data = 8'hB2;
      chk("pre_reset_active", {31'd0, rx_active}, 32'd1);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("async_rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
      chk("async_rst_stream", {23'd0, axis.tlast, axis.tdata}, 32'd0);
      chk("async_rst_status", {25'd0, linestate, vbus, rx_active, rx_error, overflow}, 32'd0);
      ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      axis.tready = 1'b1;
      bus(1'b0, 1'b0, 8'h00);
      m_ls = 2'b00; m_vb = 2'b00;
      pkt = '{8'hC3, 8'h99, 8'h00, 8'hFF};
      send_pkt(pkt, 1'b1, 1'b0, 0);
      drain();

      // Randomized packets; sink stalls only between packets.
      for (int p = 0; p < 24; p++) begin
         int len;
         len = int'($urandom_range(10));
         pkt = {};
         for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
         send_pkt(pkt, 1'($urandom), 1'($urandom), 30);
         for (int g = 0; g < int'($urandom_range(5)); g++) begin
            axis.tready = 1'($urandom);
            bus(1'b0, 1'b0, 8'($urandom));
         end
         axis.tready = 1'b1;
      end
      drain();
      chk("rand_no_overflow", {31'd0, overflow}, 32'd0);

      chk("stream_len", got_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < got_q.size()) chk($sformatf("stream_byte%0d", i), {23'd0, got_q[i]},
                                   {23'd0, exp_q[i]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
